// File: rtl/game_pacer.sv
// game_pacer: pacing and scoring engine for the road game.
//
// Generates the scroll ticks (upsig, upsig_fast), the enemy drop strobe and
// the difficulty ramp, and runs the score counter and the IDLE/RUN/CRASH game
// FSM. It sits between the input debouncers and the render/collision block.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   start_n     start button, active low (IDLE -> RUN)
//   restart_n   restart button, active low (CRASH -> IDLE, reloads everything)
//   colision    collision flag from the render/collision block
//   upsig       1-cycle scroll tick, RUN only
//   upsig_fast  1-cycle fast scroll tick, RUN only
//   drop        1-cycle enemy drop strobe, RUN only
//   alive       state == RUN and no collision
//   flash_red   crash flash bit, toggles on each base tick while in CRASH
//   level       difficulty level, saturating
//   score       score, binary or 4-digit BCD
//   state       00 IDLE, 01 RUN, 10 CRASH (also serves as the FSM debug view)
//
// Build option:
//   PACER_SCORE_BCD_EN  when defined, score is 4 BCD digits (16 bits,
//                       saturating at 9999) and SCORE_W is ignored. When
//                       undefined, score is SCORE_W bits binary, saturating
//                       at all-ones.
module game_pacer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int ACCEL_CYCLES = 250_000_000,
  parameter int TOPE_W       = 18,
  parameter int TOPE_INIT    = 131071,
  parameter int TOPE_DEC     = 5000,
  parameter int TOPE_MIN     = 20000,
  parameter int FAST_OFFSET  = 9000,
  parameter int DROP_W       = 26,
  parameter int DROP_INIT    = 13_286_901,
  parameter int DROP_DEC     = 40000,
  parameter int DROP_MIN     = 2_000_000,
  parameter int SCORE_W      = 6,
  parameter int LEVEL_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_n,
  input  logic               restart_n,
  input  logic               colision,
  output logic               upsig,
  output logic               upsig_fast,
  output logic               drop,
  output logic               alive,
  output logic               flash_red,
  output logic [LEVEL_W-1:0] level,
`ifdef PACER_SCORE_BCD_EN
  output logic [15:0]        score,
`else
  output logic [SCORE_W-1:0] score,
`endif
  output logic [1:0]         state
);

`ifdef PACER_SCORE_BCD_EN
  localparam int SC_W = 16;
`else
  localparam int SC_W = SCORE_W;
`endif

  localparam int ACC_W  = $clog2(ACCEL_CYCLES + 1);
  localparam int SCNT_W = $clog2(CLK_HZ + 1);

  localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'(ACCEL_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(CLK_HZ - 1);

  localparam logic [TOPE_W-1:0] TOPE_INIT_C = TOPE_W'(TOPE_INIT);
  localparam logic [TOPE_W-1:0] TOPE_DEC_C  = TOPE_W'(TOPE_DEC);
  localparam logic [TOPE_W-1:0] TOPE_MIN_C  = TOPE_W'(TOPE_MIN);
  localparam logic [TOPE_W-1:0] FAST_OFF_C  = TOPE_W'(FAST_OFFSET);
  // One extra bit so MIN+DEC cannot overflow the register width.
  localparam logic [TOPE_W:0]   TOPE_THR_C  = (TOPE_W + 1)'(TOPE_MIN + TOPE_DEC);

  localparam logic [DROP_W-1:0] DROP_INIT_C = DROP_W'(DROP_INIT);
  localparam logic [DROP_W-1:0] DROP_DEC_C  = DROP_W'(DROP_DEC);
  localparam logic [DROP_W-1:0] DROP_MIN_C  = DROP_W'(DROP_MIN);
  localparam logic [DROP_W:0]   DROP_THR_C  = (DROP_W + 1)'(DROP_MIN + DROP_DEC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_CRASH = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [TOPE_W-1:0]  base_cnt_q, base_cnt_d;
  logic [TOPE_W-1:0]  fast_cnt_q, fast_cnt_d;
  logic               base_tick_q, base_tick_d;
  logic               fast_tick_q, fast_tick_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               drop_tick_q, drop_tick_d;
  logic [ACC_W-1:0]   accel_cnt_q, accel_cnt_d;
  logic [SCNT_W-1:0]  score_cnt_q, score_cnt_d;
  logic [TOPE_W-1:0]  tope_q, tope_d;
  logic [DROP_W-1:0]  drop_per_q, drop_per_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SC_W-1:0]    score_q, score_d;
  logic               flash_q, flash_d;

  logic               run_ok;
  logic               reload;
  logic [TOPE_W-1:0]  fast_lim;
  logic               base_wrap, fast_wrap, drop_wrap, accel_wrap, score_wrap;
  logic [SC_W-1:0]    score_inc;

  assign run_ok     = (state_q == S_RUN) & ~colision;
  assign reload     = (state_q == S_CRASH) & ~restart_n;
  // tope never drops below TOPE_MIN > FAST_OFFSET, so this cannot underflow.
  assign fast_lim   = tope_q - FAST_OFF_C;
  // >= (not ==) so that a shrinking period never strands a counter above it.
  assign base_wrap  = base_cnt_q >= tope_q;
  assign fast_wrap  = fast_cnt_q >= fast_lim;
  assign drop_wrap  = drop_cnt_q >= drop_per_q;
  assign accel_wrap = accel_cnt_q == ACC_LAST;
  assign score_wrap = score_cnt_q == SCNT_LAST;

  // Saturating score increment.
`ifdef PACER_SCORE_BCD_EN
  always_comb begin
    logic carry;
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] >= 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    if (score_q == 16'h9999) begin
      score_inc = score_q;
    end
  end
`else
  always_comb begin
    score_inc = (score_q == '1) ? score_q : score_q + 1'b1;
  end
`endif

  // FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!start_n)   state_d = S_RUN;
      S_RUN:   if (colision)   state_d = S_CRASH;
      S_CRASH: if (!restart_n) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. Every pulse is gated with the live collision flag so a
  // tick coinciding with a crash is suppressed.
  always_comb begin
    alive      = (state_q == S_RUN) & ~colision;
    upsig      = base_tick_q & alive;
    upsig_fast = fast_tick_q & alive;
    drop       = drop_tick_q & alive;
    flash_red  = flash_q;
    level      = level_q;
    score      = score_q;
    state      = state_q;
  end

  // Datapath next-state.
  always_comb begin
    base_cnt_d  = base_wrap ? '0 : base_cnt_q + 1'b1;
    base_tick_d = base_wrap;
    fast_cnt_d  = fast_wrap ? '0 : fast_cnt_q + 1'b1;
    fast_tick_d = fast_wrap;
    flash_d     = (state_q == S_CRASH) ? (flash_q ^ base_tick_q) : 1'b0;

    drop_cnt_d  = drop_cnt_q;
    drop_tick_d = 1'b0;
    accel_cnt_d = accel_cnt_q;
    score_cnt_d = score_cnt_q;
    tope_d      = tope_q;
    drop_per_d  = drop_per_q;
    level_d     = level_q;
    score_d     = score_q;

    if (run_ok) begin
      drop_cnt_d  = drop_wrap ? '0 : drop_cnt_q + 1'b1;
      drop_tick_d = drop_wrap;

      if (accel_wrap) begin
        accel_cnt_d = '0;
        level_d     = (level_q == '1) ? level_q : level_q + 1'b1;
        tope_d      = ({1'b0, tope_q} >= TOPE_THR_C) ? tope_q - TOPE_DEC_C : TOPE_MIN_C;
        drop_per_d  = ({1'b0, drop_per_q} >= DROP_THR_C) ? drop_per_q - DROP_DEC_C
                                                         : DROP_MIN_C;
      end else begin
        accel_cnt_d = accel_cnt_q + 1'b1;
      end

      if (score_wrap) begin
        score_cnt_d = '0;
        score_d     = score_inc;
      end else begin
        score_cnt_d = score_cnt_q + 1'b1;
      end
    end

    // Restart from CRASH reloads every reset value; the FSM handles state.
    if (reload) begin
      base_cnt_d  = '0;
      base_tick_d = 1'b0;
      fast_cnt_d  = '0;
      fast_tick_d = 1'b0;
      flash_d     = 1'b0;
      drop_cnt_d  = '0;
      drop_tick_d = 1'b0;
      accel_cnt_d = '0;
      score_cnt_d = '0;
      tope_d      = TOPE_INIT_C;
      drop_per_d  = DROP_INIT_C;
      level_d     = '0;
      score_d     = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_cnt_q  <= '0;
      base_tick_q <= 1'b0;
      fast_cnt_q  <= '0;
      fast_tick_q <= 1'b0;
      flash_q     <= 1'b0;
      drop_cnt_q  <= '0;
      drop_tick_q <= 1'b0;
      accel_cnt_q <= '0;
      score_cnt_q <= '0;
      tope_q      <= TOPE_INIT_C;
      drop_per_q  <= DROP_INIT_C;
      level_q     <= '0;
      score_q     <= '0;
    end else begin
      base_cnt_q  <= base_cnt_d;
      base_tick_q <= base_tick_d;
      fast_cnt_q  <= fast_cnt_d;
      fast_tick_q <= fast_tick_d;
      flash_q     <= flash_d;
      drop_cnt_q  <= drop_cnt_d;
      drop_tick_q <= drop_tick_d;
      accel_cnt_q <= accel_cnt_d;
      score_cnt_q <= score_cnt_d;
      tope_q      <= tope_d;
      drop_per_q  <= drop_per_d;
      level_q     <= level_d;
      score_q     <= score_d;
    end
  end

endmodule

// File: tb/tb_game_pacer.sv
// Testbench for game_pacer with small parameters. Each driven cycle pushes
// the expected output vector (from a reference model built on the game rules)
// into exp_q; a monitor at the falling edge pops and compares.
module tb_game_pacer;

  localparam int ACC    = 100;
  localparam int HZ     = 10;
  localparam int T_INIT = 20;
  localparam int T_DEC  = 5;
  localparam int T_MIN  = 12;
  localparam int F_OFF  = 4;
  localparam int D_INIT = 30;
  localparam int D_DEC  = 10;
  localparam int D_MIN  = 15;
  localparam int SW     = 3;
  localparam int LW     = 4;
`ifdef PACER_SCORE_BCD_EN
  localparam int OSW = 16;
`else
  localparam int OSW = SW;
`endif

  logic           clk;
  logic           reset;
  logic           start_n;
  logic           restart_n;
  logic           colision;
  logic           upsig;
  logic           upsig_fast;
  logic           drop;
  logic           alive;
  logic           flash_red;
  logic [LW-1:0]  level;
  logic [OSW-1:0] score;
  logic [1:0]     state;

  game_pacer #(
    .CLK_HZ(HZ), .ACCEL_CYCLES(ACC), .TOPE_W(18), .TOPE_INIT(T_INIT),
    .TOPE_DEC(T_DEC), .TOPE_MIN(T_MIN), .FAST_OFFSET(F_OFF), .DROP_W(26),
    .DROP_INIT(D_INIT), .DROP_DEC(D_DEC), .DROP_MIN(D_MIN), .SCORE_W(SW),
    .LEVEL_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .start_n(start_n), .restart_n(restart_n),
    .colision(colision), .upsig(upsig), .upsig_fast(upsig_fast), .drop(drop),
    .alive(alive), .flash_red(flash_red), .level(level), .score(score),
    .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Level, periods and score follow from the count of RUN-without-collision
  // cycles since the last reload; tick phases are plain integers.
  int m_state;
  int m_bp, m_fp, m_dp;
  int m_run;
  bit m_bt, m_ft, m_dt, m_flash;
  bit p_rst, p_st, p_rs, p_col;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int m_tope();
    return imax(T_INIT - T_DEC * (m_run / ACC), T_MIN);
  endfunction

  function automatic int m_dper();
    return imax(D_INIT - D_DEC * (m_run / ACC), D_MIN);
  endfunction

  function automatic logic [15:0] m_score();
    int n;
    logic [15:0] s;
`ifdef PACER_SCORE_BCD_EN
    n = imin(m_run / HZ, 9999);
    s = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
`else
    n = imin(m_run / HZ, (1 << SW) - 1);
    s = 16'(n);
`endif
    return s;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_bp = 0; m_fp = 0; m_dp = 0; m_run = 0;
    m_bt = 1'b0; m_ft = 1'b0; m_dt = 1'b0; m_flash = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_edge();
    int  tope;
    int  dper;
    bit  nflash;
    bit  run_ok;
    if (p_rst || (m_state == 2 && !p_rs)) begin
      model_reset();
      return;
    end
    tope   = m_tope();
    dper   = m_dper();
    nflash = (m_state == 2) ? (m_flash ^ m_bt) : 1'b0;
    m_bt   = (m_bp >= tope);
    m_bp   = m_bt ? 0 : m_bp + 1;
    m_ft   = (m_fp >= tope - F_OFF);
    m_fp   = m_ft ? 0 : m_fp + 1;
    run_ok = (m_state == 1) && !p_col;
    if (run_ok) begin
      m_dt = (m_dp >= dper);
      m_dp = m_dt ? 0 : m_dp + 1;
      m_run++;
    end else begin
      m_dt = 1'b0;
    end
    m_flash = nflash;
    case (m_state)
      0: if (!p_st) m_state = 1;
      1: if (p_col) m_state = 2;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] exp_vec(bit col);
    logic [31:0] v;
    bit a;
    v = '0;
    a = (m_state == 1) && !col;
    v[0] = m_bt & a;
    v[1] = m_ft & a;
    v[2] = m_dt & a;
    v[3] = a;
    v[4] = m_flash;
    v[8 +: 16] = m_score();
    v[24 +: 4] = 4'(imin(m_run / ACC, (1 << LW) - 1));
    v[28 +: 2] = 2'(m_state);
    return v;
  endfunction

  function automatic logic [31:0] dut_vec();
    logic [31:0] v;
    v = '0;
    v[0] = upsig;
    v[1] = upsig_fast;
    v[2] = drop;
    v[3] = alive;
    v[4] = flash_red;
    v[8 +: OSW] = score;
    v[24 +: 4] = level;
    v[28 +: 2] = state;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rst_v, input bit st_n, input bit rs_n, input bit col);
    @(posedge clk);
    #1;
    model_edge();
    reset     = rst_v;
    start_n   = st_n;
    restart_n = rs_n;
    colision  = col;
    if (rst_v) model_reset();
    p_rst = rst_v; p_st = st_n; p_rs = rs_n; p_col = col;
    exp_q.push_back(exp_vec(col));
  endtask

  // Direct check of all outputs against their reset values.
  task automatic check_reset_state(input string tag);
    #1;
    n_cmp++;
    if (state !== 2'b00 || upsig !== 1'b0 || upsig_fast !== 1'b0 || drop !== 1'b0 ||
        alive !== 1'b0 || flash_red !== 1'b0 || level !== '0 || score !== '0) begin
      n_err++;
      $display("FAIL reset state (%s) t=%0t st=%0d lvl=%0d sc=%0h fl=%0b al=%0b dr=%0b uf=%0b up=%0b",
               tag, $time, state, level, score, flash_red, alive, drop, upsig_fast, upsig);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_vec();
      n_cmp++;
      if (a !== e) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL outputs t=%0t got st=%0d lvl=%0d sc=%0h fl=%0b al=%0b dr=%0b uf=%0b up=%0b expected st=%0d lvl=%0d sc=%0h fl=%0b al=%0b dr=%0b uf=%0b up=%0b",
                   $time, a[29:28], a[27:24], a[23:8], a[4], a[3], a[2], a[1], a[0],
                   e[29:28], e[27:24], e[23:8], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL timeout: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $display("TEST FAILED");
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; start_n = 1'b1; restart_n = 1'b1; colision = 1'b0;
    model_reset();
    p_rst = 1'b1; p_st = 1'b1; p_rs = 1'b1; p_col = 1'b0;

    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    check_reset_state("power-on");

    // IDLE: random restart/collision must not move anything.
    repeat (200) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Start, then a long clean RUN through several levels and score saturation.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (350) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);

    // Collide exactly on a base tick cycle.
    for (int i = 0; i < 40 && !(m_bp >= m_tope()); i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (!(m_bp >= m_tope())) begin
      n_err++;
      $display("FAIL wait expired: no base tick cycle found within 40 cycles t=%0t", $time);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);

    // CRASH dwell: flash toggles, score/level frozen.
    repeat (60) step(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));

    // Restart, then start and collision together in IDLE.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Random play.
    repeat (2000) begin
      step(1'b0, 1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 29) != 0),
           1'($urandom_range(0, 39) == 0));
    end

    // Get into RUN, then hit reset mid-cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (120) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_reset_state("mid-run");
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    if (n_err == 0) $display("TEST PASSED");
    else            $display("TEST FAILED");
    $finish;
  end

endmodule
